// File: rtl/tcdm_dma_responder.sv
// TCDM target responder: round-robin arbitration of NB_PORTS request ports into one
// single-ported word memory, with a one-cycle response. Optional macro: TCDM_RESP_STALL_EN.
module tcdm_dma_responder #(
    parameter int unsigned NB_PORTS   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NB_WORDS   = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
`ifdef TCDM_RESP_STALL_EN
    input  logic                                 stall_en_i,
`endif
    input  logic [NB_PORTS-1:0]                  req_i,
    input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]  add_i,
    input  logic [NB_PORTS-1:0]                  wen_i,
    input  logic [NB_PORTS-1:0][BE_WIDTH-1:0]    be_i,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0] data_i,
    output logic [NB_PORTS-1:0]                  gnt_o,
    output logic [NB_PORTS-1:0]                  r_valid_o,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_data_o
);

    localparam int unsigned PTR_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int unsigned OFF_W = $clog2(BE_WIDTH);
    localparam int unsigned IDX_W = $clog2(NB_WORDS);

    logic [PTR_W-1:0]                  rr_ptr_q;
    logic [PTR_W-1:0]                  gnt_idx;
    logic                              gnt_any;
    logic                              stall;
    logic [NB_PORTS-1:0]               gnt;
    logic [31:0]                       cand;
    logic [IDX_W-1:0]                  word_idx;
    logic [NB_PORTS-1:0]               r_valid_q;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0]             mem_q [NB_WORDS];

`ifdef TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11; bit 0 of the current value gates the grants.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = stall_en_i & lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Search upward from rr_ptr_q, wrapping; grants are held off while in reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned j = 0; j < NB_PORTS; j++) begin
            cand = (32'(rr_ptr_q) + j) % NB_PORTS;
            if (!gnt_any && !stall && rst_ni && req_i[cand[PTR_W-1:0]]) begin
                gnt[cand[PTR_W-1:0]] = 1'b1;
                gnt_idx              = cand[PTR_W-1:0];
                gnt_any              = 1'b1;
            end
        end
    end

    assign word_idx = add_i[gnt_idx][OFF_W +: IDX_W];
    assign gnt_o    = gnt;

    always_ff @(posedge clk_i) begin
        if (gnt_any && !wen_i[gnt_idx]) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (be_i[gnt_idx][b]) begin
                    mem_q[word_idx][b*8 +: 8] <= data_i[gnt_idx][b*8 +: 8];
                end
            end
        end
    end

    // Read data is the pre-write word; write responses carry zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= gnt;
            r_data_q  <= '0;
            if (gnt_any) begin
                rr_ptr_q <= (gnt_idx == PTR_W'(NB_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                if (wen_i[gnt_idx]) begin
                    r_data_q[gnt_idx] <= mem_q[word_idx];
                end
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;

endmodule

// File: doc/tcdm_dma_responder.md
Name: tcdm_dma_responder

Overview:
- Synthesizable TCDM-side responder: the target end of the 4-port TCDM initiator bus driven by the cluster DMA.
- Accepts requests on NB_PORTS TCDM ports, arbitrates round-robin into one single-ported word memory, and returns grant and response data with TCDM timing.
- Used as the TCDM stand-in in DMA subsystem benches and in small-cluster configurations with a single DMA-private bank.

Parameters:
- NB_PORTS, 4, number of TCDM request ports.
- DATA_WIDTH, 32, word width in bits.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ADDR_WIDTH, 32, request address width; byte address.
- NB_WORDS, 1024, memory depth in words; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NB_PORTS  request valid per port.
- add_i  in  NB_PORTS x ADDR_WIDTH  byte address per port.
- wen_i  in  NB_PORTS  1 = read, 0 = write.
- be_i  in  NB_PORTS x BE_WIDTH  byte enables; writes only.
- data_i  in  NB_PORTS x DATA_WIDTH  write data.
- gnt_o  out  NB_PORTS  grant, combinational in the request cycle.
- r_valid_o  out  NB_PORTS  response valid, one cycle after grant.
- r_data_o  out  NB_PORTS x DATA_WIDTH  read data, valid with r_valid_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - gnt_o and r_valid_o are 0.
  - r_data_o is 0.
  - Round-robin pointer is 0.
  - Memory contents are not reset.
- Word index: add_i[$clog2(BE_WIDTH) +: $clog2(NB_WORDS)]. Upper bits are ignored, so addresses alias (wrap) modulo NB_WORDS*BE_WIDTH. Low byte-offset bits are ignored.
- Arbitration:
  - Each cycle, at most one port is granted: the first port with req_i=1, searching from rr_ptr upward, wrapping from NB_PORTS-1 to 0.
  - gnt_o is combinational from req_i and rr_ptr. gnt_o[i] is never 1 while req_i[i]=0.
  - On any grant to port k, rr_ptr <= (k+1) mod NB_PORTS on the next edge. rr_ptr holds when there is no grant.
  - Ungranted requesters hold their request unchanged. The responder does not check this.
- Write (granted, wen=0): memory bytes with be=1 are updated at the clock edge. Bytes with be=0 are unchanged. be=0 entirely is a legal no-op write.
- Read (granted, wen=1): the word is read at the clock edge.
- Response:
  - Exactly one cycle after each grant, r_valid_o[k]=1 for exactly one cycle, for both reads and writes.
  - Reads: r_data_o[k] carries the pre-write memory word.
  - Writes: r_data_o[k] is 0.
  - r_data_o on ports without r_valid is 0.
- Back-to-back accesses:
  - Read-after-write to the same word in consecutive cycles returns the newly written data. There is no hazard, because the write is committed before the next read.
  - Full throughput: one access per cycle. No internal buffering beyond the 1-stage response register.
- Simultaneous events: a new grant and a response on the same port in the same cycle is legal and required for a continuously requesting port.
- Reset mid-operation: an in-flight response is dropped (r_valid_o forced to 0). Memory keeps its contents except for the byte lanes of an in-progress write in that cycle, which are undefined.

Optional Feature:
- Macro TCDM_RESP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is reset to 16'hACE1 and advances every cycle.
  - When LFSR bit 0 is 1, all grants are suppressed that cycle. rr_ptr holds and memory is untouched.
  - Adds input stall_en_i (1 bit). When stall_en_i=0, there are no stalls.
  - Used to verify initiator gnt-wait handling.
- When undefined: the LFSR and stall_en_i are absent. The arbiter grants every cycle in which any request is present.

Test Plan:
- Single write then read: port 0 writes 32'hDEADBEEF at 0x10, be=4'hF; next cycle port 0 reads 0x10 -> gnt same cycle each; r_valid one cycle later; read r_data=32'hDEADBEEF.
- Byte enables: word 0x20 holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101 -> subsequent read returns 32'h11BB33DD.
- Round robin: all 4 ports request continuously from reset -> grant order 0,1,2,3,0,...; r_valid order lags by one cycle; each port gets exactly 1 grant per 4 cycles.
- Aliasing: NB_WORDS=1024, write 32'h5 at 0x0000_1004 -> read of 0x0000_0004 returns 32'h5.
- Reset mid-transfer: assert rst_ni=0 in the cycle after a read grant -> r_valid_o=0 immediately and stays 0; after release, rr_ptr=0 and port 0 wins a 4-way contention.
- With TCDM_RESP_STALL_EN and stall_en_i=1: port 2 issues 100 reads -> every request is eventually granted; no r_valid without a preceding grant; total stalled cycles match the LFSR bit-0 count from seed 16'hACE1.
